add_accum: RTL and testbench
============================

# add_accum

Parametrised, pipelined arithmetic unit: the sequential successor to the combinational `ui_in + uio_in` adder used in the top-level wrapper. It registers two unsigned operands and computes one of four operations: add, subtract, accumulate or clear. It has selectable wrap or saturate arithmetic, a carry/borrow flag and a count of accumulations. It sits between the top-level pin mapping and `uo_out`, and takes `ena` as a pipeline-advance enable.

## Interface
Parameters:
- `WIDTH`, 8: operand, result and accumulator width in bits; legal values are 2 or more.
- `SATURATE`, 0: 0 means results wrap modulo 2^WIDTH; 1 means results clamp.
- `CNT_W`, 8: width of `acc_count`; legal values are 1 or more.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  pipeline advance. When 0, every register holds.
- `in_valid`  in  1  operands and `op` are valid this cycle.
- `a`  in  WIDTH  unsigned operand A.
- `b`  in  WIDTH  unsigned operand B. Ignored for ACC and CLR.
- `op`  in  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- `result`  out  WIDTH  registered result.
- `carry`  out  1  ADD/ACC: carry-out of the MSB. SUB: borrow (1 when a<b). CLR: 0.
- `out_valid`  out  1  `result` and `carry` correspond to a newly completed operation.
- `acc_count`  out  CNT_W  number of ACC operations since the last CLR or reset. Saturates at all-ones.

## Operation
- **Stage 1 (capture).** On a clock edge with `ena`=1:
  - `a`, `b` and `op` load into `a_q`, `b_q` and `op_q`.
  - `v1` takes the value of `in_valid`.
  - When `in_valid`=0, the operand registers may load don't-care values; only `v1` matters.
- **Stage 2 (execute).** On a clock edge with `ena`=1 and `v1`=1:
  - ADD: form the (WIDTH+1)-bit sum `a_q+b_q`. `carry` is bit WIDTH; the raw result is bits WIDTH-1:0.
  - SUB: form `a_q-b_q` modulo 2^WIDTH. `carry` = (`a_q`<`b_q`).
  - ACC: form the (WIDTH+1)-bit sum `acc+a_q`. Update `acc`, `result` and `carry` as for ADD. `acc_count` increments, saturating at 2^CNT_W-1.
  - CLR: `acc`, `result`, `carry` and `acc_count` all become 0.
- **SATURATE=1.**
  - ADD or ACC with carry=1: the result, and for ACC the stored `acc`, become all-ones.
  - SUB with borrow: the result becomes 0.
  - `carry` still reports the overflow or borrow.
- **SATURATE=0.** Results wrap; the stored `acc` is the wrapped value.
- **Stage 2 with `ena`=1 and `v1`=0.** `result`, `carry`, `acc` and `acc_count` hold; `out_valid` becomes 0.
- **`out_valid`.** Registered as a copy of `v1`, updated only when `ena`=1.
  - Downstream consumes a result only on a cycle where `ena`=1 and `out_valid`=1.
  - While `ena`=0, `out_valid` holds and must not be counted again.
- **Accumulator ownership.** `acc` is read and written only in stage 2, so back-to-back ACC operations chain with no hazard or stall.
- **Reset.** `rst_n`=0 asynchronously clears `a_q`, `b_q`, `op_q`, `v1`, `acc`, `result`, `carry`, `out_valid` and `acc_count` to 0. In-flight operations are discarded and not replayed.
- **Internal state.** The `acc` register is internal and not a port. Its value is visible as `result` after each ACC.

## Timing
- **Latency.** An operation presented with `in_valid`=1 at ena-edge N appears with `out_valid`=1 after ena-edge N+1, i.e. 2 `ena`-qualified cycles.
- **Throughput.** One operation per `ena` cycle. There is no backpressure.
- **`ena` gaps.** `ena` low for k cycles stretches the latency by k. No data is lost or duplicated.
- **Reset values.** `result`=0, `carry`=0, `out_valid`=0, `acc_count`=0.
- **Reset release.** The first valid `out_valid` after reset release needs 2 `ena` edges.
- **Simultaneous CLR.** A CLR in stage 2 while an ACC is in stage 1 is fine: the next-cycle ACC adds to 0 and `acc_count` becomes 1.
- **`acc_count` at all-ones.** An ACC leaves `acc_count` unchanged but still updates `acc`.

## Test plan
All scenarios use WIDTH=8 and CNT_W=8 unless stated.
- **ADD wrap (SATURATE=0).** ADD 200+100 → `result`=44, `carry`=1, `out_valid` high 2 cycles after issue. Then ADD 3+4 → 7, `carry`=0.
- **SUB.** SUB 5-7 with SATURATE=0 → `result`=254, `carry`=1. The same with SATURATE=1 → `result`=0, `carry`=1. SUB 9-9 → 0, `carry`=0.
- **Chained ACC.** Back-to-back ACC of a=100 three times → `result` 100, 200, 44 and `carry` 0, 0, 1, with `acc_count` 1, 2, 3. Next, CLR → `result`=0, `acc_count`=0. Then ACC a=5 → `result`=5.
- **Saturating ACC (SATURATE=1).** ACC 200 then ACC 100 → `result` 200, then 255 with `carry`=1. A following ACC 0 → 255, `carry`=0.
- **`ena` stall.** Stream ADD 1+1, 2+2, 3+3 with `ena` low for 3 cycles mid-stream. Outputs and `out_valid` hold during the gap. Exactly three results, 2, 4 and 6, are consumed in order.
- **Reset and count saturation.**
  - Assert `rst_n` low asynchronously mid-stream → all outputs 0 before the next clock edge. After release, the in-flight operation is not produced.
  - With CNT_W=2, five ACCs → `acc_count` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/add_accum.sv
// rtl/add_accum.sv - two-stage add/sub/accumulate/clear unit with wrap or saturate arithmetic
module add_accum #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             out_valid,
  output logic [CNT_W-1:0] acc_count
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               SAT      = (SATURATE != 0);

  logic [WIDTH-1:0] a_q, b_q, acc;
  logic [1:0]       op_q;
  logic             v1;

  logic [WIDTH:0]   sum_ab, sum_acc;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  logic [WIDTH-1:0] nxt_result, nxt_acc;
  logic             nxt_carry;
  logic [CNT_W-1:0] nxt_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      v1   <= 1'b0;
    end else if (ena) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
      v1   <= in_valid;
    end
  end

  assign sum_ab  = {1'b0, a_q} + {1'b0, b_q};
  assign sum_acc = {1'b0, acc} + {1'b0, a_q};
  assign diff    = a_q - b_q;
  assign borrow  = (a_q < b_q);

  always_comb begin
    nxt_result = result;
    nxt_carry  = carry;
    nxt_acc    = acc;
    nxt_count  = acc_count;
    case (op_q)
      OP_ADD: begin
        nxt_carry  = sum_ab[WIDTH];
        nxt_result = (SAT && sum_ab[WIDTH]) ? ALL_ONES : sum_ab[WIDTH-1:0];
      end
      OP_SUB: begin
        nxt_carry  = borrow;
        nxt_result = (SAT && borrow) ? '0 : diff;
      end
      OP_ACC: begin
        // The stored accumulator follows the clamped value, so a saturated acc stays pinned.
        nxt_carry  = sum_acc[WIDTH];
        nxt_result = (SAT && sum_acc[WIDTH]) ? ALL_ONES : sum_acc[WIDTH-1:0];
        nxt_acc    = nxt_result;
        if (acc_count != CNT_MAX) begin
          nxt_count = acc_count + CNT_W'(1);
        end
      end
      OP_CLR: begin
        nxt_carry  = 1'b0;
        nxt_result = '0;
        nxt_acc    = '0;
        nxt_count  = '0;
      end
      default: begin
        nxt_result = result;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      result    <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      acc_count <= '0;
    end else if (ena) begin
      out_valid <= v1;
      if (v1) begin
        acc       <= nxt_acc;
        result    <= nxt_result;
        carry     <= nxt_carry;
        acc_count <= nxt_count;
      end
    end
  end

endmodule

// File: tb/tb_add_accum.sv
// tb/tb_add_accum.sv - scoreboard bench for add_accum: wrap, saturate and 2-bit count instances
module tb_add_accum;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] ACC = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] vld;
  logic [7:0] a [3];
  logic [7:0] b [3];
  logic [1:0] op [3];
  logic [7:0] res [3];
  logic [2:0] car;
  logic [2:0] ov;
  logic [7:0] cnt [2];
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  add_accum #(.WIDTH(8), .SATURATE(0), .CNT_W(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(vld[0]), .a(a[0]), .b(b[0]), .op(op[0]),
    .result(res[0]), .carry(car[0]), .out_valid(ov[0]), .acc_count(cnt[0]));

  add_accum #(.WIDTH(8), .SATURATE(1), .CNT_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(vld[1]), .a(a[1]), .b(b[1]), .op(op[1]),
    .result(res[1]), .carry(car[1]), .out_valid(ov[1]), .acc_count(cnt[1]));

  add_accum #(.WIDTH(8), .SATURATE(0), .CNT_W(2)) u_cnt2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(vld[2]), .a(a[2]), .b(b[2]), .op(op[2]),
    .result(res[2]), .carry(car[2]), .out_valid(ov[2]), .acc_count(cnt2));

  typedef struct {
    logic [7:0] r;
    logic       c;
    int         n;
    int         e;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ena_edges = 0;

  always @(posedge clk) begin
    if (ena && rst_n) ena_edges <= ena_edges + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic consume(input int d, input logic [7:0] r, input logic c, input int n);
    exp_t t;
    int   sz;
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    n_vec++;
    if (sz == 0) begin
      n_err++;
      $display("FAIL dut%0d unexpected output: result=%0d carry=%0d count=%0d", d, r, c, n);
    end else begin
      case (d)
        0:       t = q0.pop_front();
        1:       t = q1.pop_front();
        default: t = q2.pop_front();
      endcase
      if (r !== t.r || c !== t.c || n != t.n || ena_edges != t.e) begin
        n_err++;
        $display("FAIL dut%0d output: result=%0d carry=%0d count=%0d edge=%0d, expected %0d/%0d/%0d/%0d",
                 d, r, c, n, ena_edges, t.r, t.c, t.n, t.e);
      end
    end
  endtask

  // Monitor: a result is consumed on a cycle where ena and out_valid are both high.
  always @(negedge clk) begin
    if (rst_n && ena) begin
      if (ov[0]) consume(0, res[0], car[0], int'(cnt[0]));
      if (ov[1]) consume(1, res[1], car[1], int'(cnt[1]));
      if (ov[2]) consume(2, res[2], car[2], int'(cnt2));
    end
  end

  task automatic drive(input int d, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    vld[d] = 1'b1;
    a[d]   = x;
    b[d]   = y;
    op[d]  = o;
    @(posedge clk);
    while (!ena) @(posedge clk);
    #1 vld[d] = 1'b0;
  endtask

  task automatic issue(input int d, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input logic ec, input int en);
    exp_t t;
    t.r = er;
    t.c = ec;
    t.n = en;
    t.e = ena_edges + 2;
    case (d)
      0:       q0.push_back(t);
      1:       q1.push_back(t);
      default: q2.push_back(t);
    endcase
    drive(d, o, x, y);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && (q0.size() + q1.size() + q2.size()) > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 chk(name, q0.size() + q1.size() + q2.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    vld   = 3'b000;
    for (int i = 0; i < 3; i++) begin
      a[i]  = 8'd0;
      b[i]  = 8'd0;
      op[i] = ADD;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_result%0d", d), int'(res[d]), 0);
      chk($sformatf("reset_carry%0d", d), int'(car[d]), 0);
      chk($sformatf("reset_valid%0d", d), int'(ov[d]), 0);
    end
    chk("reset_count0", int'(cnt[0]), 0);
    chk("reset_count1", int'(cnt[1]), 0);
    chk("reset_count2", int'(cnt2), 0);
    rst_n = 1'b1;

    // Wrapping instance: add, subtract, chained accumulate, clear then accumulate
    issue(0, ADD, 8'd200, 8'd100, 8'd44,  1'b1, 0);
    issue(0, ADD, 8'd3,   8'd4,   8'd7,   1'b0, 0);
    issue(0, SUB, 8'd5,   8'd7,   8'd254, 1'b1, 0);
    issue(0, SUB, 8'd9,   8'd9,   8'd0,   1'b0, 0);
    issue(0, ACC, 8'd100, 8'd0,   8'd100, 1'b0, 1);
    issue(0, ACC, 8'd100, 8'd0,   8'd200, 1'b0, 2);
    issue(0, ACC, 8'd100, 8'd0,   8'd44,  1'b1, 3);
    issue(0, CLR, 8'd0,   8'd0,   8'd0,   1'b0, 0);
    issue(0, ACC, 8'd5,   8'd0,   8'd5,   1'b0, 1);
    issue(0, CLR, 8'd0,   8'd0,   8'd0,   1'b0, 0);
    issue(0, ACC, 8'd7,   8'd0,   8'd7,   1'b0, 1);

    // Saturating instance
    issue(1, SUB, 8'd5,   8'd7,   8'd0,   1'b1, 0);
    issue(1, ADD, 8'd200, 8'd100, 8'd255, 1'b1, 0);
    issue(1, ACC, 8'd200, 8'd0,   8'd200, 1'b0, 1);
    issue(1, ACC, 8'd100, 8'd0,   8'd255, 1'b1, 2);
    issue(1, ACC, 8'd0,   8'd0,   8'd255, 1'b0, 3);

    // Two-bit accumulate counter pins at 3
    issue(2, ACC, 8'd1, 8'd0, 8'd1, 1'b0, 1);
    issue(2, ACC, 8'd1, 8'd0, 8'd2, 1'b0, 2);
    issue(2, ACC, 8'd1, 8'd0, 8'd3, 1'b0, 3);
    issue(2, ACC, 8'd1, 8'd0, 8'd4, 1'b0, 3);
    issue(2, ACC, 8'd1, 8'd0, 8'd5, 1'b0, 3);
    drain("drain_basic");

    // ena gap mid-stream: outputs hold and nothing is consumed twice
    issue(0, ADD, 8'd1, 8'd1, 8'd2, 1'b0, 1);
    issue(0, ADD, 8'd2, 8'd2, 8'd4, 1'b0, 1);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall_result%0d", i), int'(res[0]), 2);
      chk($sformatf("stall_valid%0d", i), int'(ov[0]), 1);
    end
    ena = 1'b1;
    issue(0, ADD, 8'd3, 8'd3, 8'd6, 1'b0, 1);
    drain("drain_stall");

    // Asynchronous reset with an operation in flight
    drive(0, ADD, 8'd10, 8'd20);
    drive(0, ADD, 8'd1,  8'd2);
    chk("pre_reset_result", int'(res[0]), 30);
    #1 rst_n = 1'b0;
    #1;
    chk("async_result", int'(res[0]), 0);
    chk("async_valid", int'(ov[0]), 0);
    chk("async_count0", int'(cnt[0]), 0);
    chk("async_count1", int'(cnt[1]), 0);
    chk("async_count2", int'(cnt2), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("no_replay_valid", int'(ov[0]), 0);
    issue(0, ADD, 8'd3, 8'd4, 8'd7, 1'b0, 0);
    issue(0, ACC, 8'd9, 8'd0, 8'd9, 1'b0, 1);
    drain("drain_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
